// File: rtl/riscv_m_pkg.sv
// Shared RV32M encodings, FSM state type and iteration constants for the
// iterative multiply/divide unit.
package riscv_m_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int MDU_ITERS = 32;
  localparam int CNT_W     = $clog2(MDU_ITERS);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MDU_ITERS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } mdu_state_e;

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
  function automatic logic a_is_signed(input logic [2:0] f3);
    return f3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM.
  function automatic logic b_is_signed(input logic [2:0] f3);
    return f3 inside {F3_MULH, F3_DIV, F3_REM};
  endfunction

  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

  // REM and REMU both have bit 1 set among the divide ops.
  function automatic logic is_rem_op(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

endpackage

// File: rtl/mdu_sign_prep.sv
// Combinational operand preparation: magnitudes, sign flags and detection of
// the divide cases whose result is known without iterating.
module mdu_sign_prep
  import riscv_m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic            sign_a,
  output logic            sign_b,
  output logic            fast,
  output logic [XLEN-1:0] fast_result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic div_zero;
  logic div_ovf;

  always_comb begin
    // NOTE: every output is given a value before any branch so no latch is
    // inferred when a case or if leaves a path unassigned.
    fast_result = '0;

    sign_a = op_a[XLEN-1] & a_is_signed(funct3);
    sign_b = op_b[XLEN-1] & b_is_signed(funct3);
    mag_a  = sign_a ? -op_a : op_a;
    mag_b  = sign_b ? -op_b : op_b;

    div_zero = is_div_op(funct3) && (op_b == '0);
    div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (op_a == INT_MIN) && (op_b == '1);
    fast     = div_zero || div_ovf;

    if (div_zero) begin
      fast_result = is_rem_op(funct3) ? op_a : '1;
    end else if (div_ovf) begin
      fast_result = is_rem_op(funct3) ? '0 : INT_MIN;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one multiplier or quotient bit per
// cycle, followed by a sign-fix cycle, with a start/busy/done handshake.
module mul_div_unit
  import riscv_m_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              kill,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic [REG_AW-1:0] rd_out
);

  mdu_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        f3_q;
  logic [REG_AW-1:0] rd_q;
  logic              sign_a_q;
  logic              sign_b_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   rem_q;

  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            sign_a;
  logic            sign_b;
  logic            fast;
  logic [XLEN-1:0] fast_result;

  mdu_sign_prep #(.XLEN(XLEN)) u_sign_prep (
    .funct3      (funct3),
    .op_a        (op_a),
    .op_b        (op_b),
    .mag_a       (mag_a),
    .mag_b       (mag_b),
    .sign_a      (sign_a),
    .sign_b      (sign_b),
    .fast        (fast),
    .fast_result (fast_result)
  );

  logic              accept;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_fits;
  logic [XLEN-1:0]   div_sub;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_result;

  // A flush in the same cycle as a request wins, so the request is dropped.
  assign accept = start && !kill && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    fix_result = '0;

    // Multiply: prod_q holds {partial high word, remaining multiplier bits};
    // the add result and the whole register shift right together.
    mul_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);

    // Divide: the low word of prod_q shifts the dividend out at the top and
    // the quotient in at the bottom. The difference fits in XLEN bits
    // whenever the divisor fits, because the remainder stays below it.
    div_shift = {rem_q, prod_q[XLEN-1]};
    div_fits  = div_shift >= {1'b0, opnd_q};
    div_sub   = div_shift[XLEN-1:0] - opnd_q;

    prod_fix = (sign_a_q ^ sign_b_q) ? -prod_q : prod_q;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    rem_fix  = sign_a_q ? -rem_q : rem_q;

    case (f3_q)
      F3_MUL:                       fix_result = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_result = quo_fix;
      default:                      fix_result = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples its inputs from before the edge, independent of
    // statement order.
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      rd_out   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done    <= 1'b0;
          state_q <= S_IDLE;
          if (accept) begin
            f3_q     <= funct3;
            rd_q     <= rd_in;
            sign_a_q <= sign_a;
            sign_b_q <= sign_b;
            cnt_q    <= '0;
            rem_q    <= '0;
            opnd_q   <= is_div_op(funct3) ? mag_b : mag_a;
            prod_q   <= {{XLEN{1'b0}}, (is_div_op(funct3) ? mag_a : mag_b)};
            if (fast) begin
              result  <= fast_result;
              rd_out  <= rd_in;
              done    <= 1'b1;
              state_q <= S_DONE;
            end else begin
              busy    <= 1'b1;
              state_q <= S_CALC;
            end
          end
        end

        S_CALC: begin
          if (kill) begin
            busy    <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            if (is_div_op(f3_q)) begin
              rem_q              <= div_fits ? div_sub : div_shift[XLEN-1:0];
              prod_q[XLEN-1:0]   <= {prod_q[XLEN-2:0], div_fits};
            end else begin
              prod_q <= {mul_sum, prod_q[XLEN-1:1]};
            end
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
              state_q <= S_FIX;
            end
          end
        end

        S_FIX: begin
          busy <= 1'b0;
          if (kill) begin
            state_q <= S_IDLE;
          end else begin
            result  <= fix_result;
            rd_out  <= rd_q;
            done    <= 1'b1;
            state_q <= S_DONE;
          end
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: latency, arithmetic results,
// divide fast paths, busy/kill/reset control and back-to-back issue.
module tb_mul_div_unit;
  import riscv_m_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        kill = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mul_div_unit #(.XLEN(32), .REG_AW(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .rd_in  (rd_in),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Advance one clock; outputs are read 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc++;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    start  = 1'b1;
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    rd_in  = rd;
    cyc    = 0;
  endtask

  task automatic wait_done(input int max_cycles, output int lat);
    lat = -1;
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (done === 1'b1) begin
        lat = cyc;
        return;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp,
                        input int exp_lat);
    int lat;
    issue(f3, a, b, rd);
    wait_done(40, lat);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (result !== exp) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", name, result, exp);
    end
    checks++;
    if (rd_out !== rd) begin
      errors++;
      $display("FAIL %s rd_out: got %0d expected %0d", name, rd_out, rd);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after done: done=%b busy=%b expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({busy, done, result, rd_out} !== '0) begin
      errors++;
      $display("FAIL reset outputs: busy=%b done=%b result=%h rd_out=%0d expected all 0",
               busy, done, result, rd_out);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_mul_timing();
    int bad_busy = 0;
    issue(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd10);
    for (int c = 1; c <= 33; c++) begin
      step();
      if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
    end
    checks++;
    if (bad_busy != 0) begin
      errors++;
      $display("FAIL mul busy window: %0d bad cycles expected 0", bad_busy);
    end
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mul cycle34 handshake: done=%b busy=%b expected 1 0", done, busy);
    end
    checks++;
    if (result !== 32'hFFFF_FFEB || rd_out !== 5'd10) begin
      errors++;
      $display("FAIL mul result: got %h rd %0d expected ffffffeb rd 10", result, rd_out);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL mul done pulse width: done=%b expected 0", done);
    end
  endtask

  task automatic test_mul_high();
    run_op("mulh",   F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 34);
    run_op("mulhu",  F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 34);
    run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 34);
  endtask

  task automatic test_divide();
    run_op("div",  F3_DIV,  32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 34);
    run_op("rem",  F3_REM,  32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, 34);
    run_op("divu", F3_DIVU, 32'd100,       32'd7, 5'd6, 32'd14,        34);
    run_op("remu", F3_REMU, 32'd100,       32'd7, 5'd7, 32'd2,         34);
  endtask

  task automatic test_fast_path();
    run_op("div0",    F3_DIV,  32'd5,         32'd0,         5'd8,  32'hFFFF_FFFF, 1);
    run_op("remu0",   F3_REMU, 32'd5,         32'd0,         5'd9,  32'd5,         1);
    run_op("div_ovf", F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
    run_op("rem_ovf", F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         1);
  endtask

  task automatic test_start_while_busy();
    int lat;
    issue(F3_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd13);
    repeat (5) step();
    start  = 1'b1;
    funct3 = F3_DIVU;
    op_a   = 32'd50;
    op_b   = 32'd5;
    rd_in  = 5'd20;
    wait_done(40, lat);
    checks++;
    if (lat !== 34 || result !== 32'd1 || rd_out !== 5'd13) begin
      errors++;
      $display("FAIL start_busy: lat %0d result %h rd %0d expected 34 00000001 13",
               lat, result, rd_out);
    end
    step();
  endtask

  task automatic test_kill();
    int done_seen = 0;
    run_op("pre_kill", F3_MUL, 32'd2, 32'd3, 5'd3, 32'd6, 34);
    issue(F3_DIVU, 32'd100, 32'd7, 5'd9);
    repeat (10) step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd6 || rd_out !== 5'd3) begin
      errors++;
      $display("FAIL kill: busy=%b done=%b result=%h rd=%0d expected 0 0 00000006 3",
               busy, done, result, rd_out);
    end
    for (int i = 0; i < 30; i++) begin
      step();
      if (done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL kill no done: saw %0d done pulses expected 0", done_seen);
    end
    // A request arriving together with a flush while idle is dropped.
    issue(F3_MUL, 32'd4, 32'd4, 5'd15);
    kill = 1'b1;
    step();
    kill = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL kill_start: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_op();
    int done_seen = 0;
    issue(F3_MUL, 32'd9, 32'd9, 5'd17);
    repeat (12) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({busy, done, result, rd_out} !== '0) begin
      errors++;
      $display("FAIL reset mid-op: busy=%b done=%b result=%h rd=%0d expected all 0",
               busy, done, result, rd_out);
    end
    for (int i = 0; i < 30; i++) begin
      step();
      if (done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL reset no done: saw %0d done pulses expected 0", done_seen);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(F3_MUL, 32'd2, 32'd3, 5'd1);
    wait_done(40, lat);
    checks++;
    if (lat !== 34 || result !== 32'd6 || rd_out !== 5'd1) begin
      errors++;
      $display("FAIL b2b first: lat %0d result %h rd %0d expected 34 00000006 1",
               lat, result, rd_out);
    end
    start  = 1'b1;
    funct3 = F3_DIVU;
    op_a   = 32'd9;
    op_b   = 32'd3;
    rd_in  = 5'd2;
    wait_done(40, lat);
    checks++;
    if (lat !== 68 || result !== 32'd3 || rd_out !== 5'd2) begin
      errors++;
      $display("FAIL b2b second: lat %0d result %h rd %0d expected 68 00000003 2",
               lat, result, rd_out);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_mul_timing();
    test_mul_high();
    test_divide();
    test_fast_path();
    test_start_while_busy();
    test_kill();
    test_reset_mid_op();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
